// File: rtl/l2_miss_queue_if.sv
// Bundle of the enqueue, memory-burst and restart signals of the L2 miss queue.
// Latency: none (wires only).
// Backpressure: valid/ready on every channel except mem read data, which is always accepted.
interface l2_miss_queue_if #(
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int LINE_BITS       = 512,
    parameter int BEAT_BITS       = 32,
    parameter int ID_WIDTH        = 8
);
    logic                       enq_valid;
    logic                       enq_ready;
    logic [ID_WIDTH-1:0]        enq_id;
    logic                       enq_fill;
    logic [LINE_ADDR_WIDTH-1:0] enq_fill_addr;
    logic                       enq_writeback;
    logic [LINE_ADDR_WIDTH-1:0] enq_wb_addr;
    logic [LINE_BITS-1:0]       enq_wb_data;

    logic                       mem_req_valid;
    logic                       mem_req_ready;
    logic                       mem_req_write;
    logic [LINE_ADDR_WIDTH-1:0] mem_req_addr;
    logic                       mem_wvalid;
    logic                       mem_wready;
    logic [BEAT_BITS-1:0]       mem_wdata;
    logic                       mem_wlast;
    logic                       mem_rvalid;
    logic [BEAT_BITS-1:0]       mem_rdata;

    logic                       restart_valid;
    logic                       restart_ready;
    logic [ID_WIDTH-1:0]        restart_id;
    logic [LINE_BITS-1:0]       restart_data;
    logic                       restart_duplicate;
    logic                       busy;

    // master is the queue itself; slave is the pipeline/memory side around it
    modport master (
        input  enq_valid, enq_id, enq_fill, enq_fill_addr, enq_writeback, enq_wb_addr, enq_wb_data,
        output enq_ready,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_wvalid, mem_wdata, mem_wlast,
        input  mem_req_ready, mem_wready, mem_rvalid, mem_rdata,
        output restart_valid, restart_id, restart_data, restart_duplicate, busy,
        input  restart_ready
    );

    modport slave (
        output enq_valid, enq_id, enq_fill, enq_fill_addr, enq_writeback, enq_wb_addr, enq_wb_data,
        input  enq_ready,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_wvalid, mem_wdata, mem_wlast,
        output mem_req_ready, mem_wready, mem_rvalid, mem_rdata,
        input  restart_valid, restart_id, restart_data, restart_duplicate, busy,
        output restart_ready
    );
endinterface

// File: rtl/l2_miss_queue.sv
// L2 miss queue: in-order writeback-then-fill bursts to memory, reissue with the fill line.
// Latency: enq -> mem_req_valid 2 cycles when empty; last read beat -> restart_valid 1 cycle.
// Backpressure: enq_ready when not full (or popping); mem req/wdata and restart held until accepted.
module l2_miss_queue #(
    parameter int DEPTH           = 8,
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int LINE_BITS       = 512,
    parameter int BEAT_BITS       = 32,
    parameter int ID_WIDTH        = 8
) (
    input  logic             clk,
    input  logic             reset,
    l2_miss_queue_if.master  bus
);
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam int NBEATS = LINE_BITS / BEAT_BITS;
    localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(NBEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WB_REQ, S_WB_DATA, S_FILL_REQ, S_FILL_DATA, S_RESTART
    } state_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]        id;
        logic                       fill;
        logic                       dup;
        logic                       wb;
        logic [LINE_ADDR_WIDTH-1:0] fill_addr;
        logic [LINE_ADDR_WIDTH-1:0] wb_addr;
        logic [LINE_BITS-1:0]       wb_data;
    } entry_t;

    entry_t              ent_q [DEPTH];
    logic [DEPTH-1:0]    vld_q;
    logic [PW-1:0]       head_q, tail_q;
    logic [CW-1:0]       count_q;
    state_t              state_q, state_d;
    logic [BCW-1:0]      beat_q;
    logic [LINE_BITS-1:0] line_q;

    entry_t head;
    entry_t new_ent;
    logic   dup_hit;
    logic   enq_fire, deq_fire, full, beat_adv;

    assign head     = ent_q[head_q];
    assign full     = (count_q == CW'(DEPTH));
    assign deq_fire = (state_q == S_RESTART) && bus.restart_ready;
    // A pop in the same cycle frees a slot, so a full queue can still take one
    assign bus.enq_ready = !full || deq_fire;
    assign enq_fire  = bus.enq_valid && bus.enq_ready;
    assign bus.busy  = (count_q != '0);

    // Merge candidates: pending original fills whose line has not yet been handed back
    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && ent_q[i].fill && !ent_q[i].dup &&
                ent_q[i].fill_addr == bus.enq_fill_addr &&
                !(PW'(i) == head_q && state_q == S_RESTART))
                dup_hit = 1'b1;
        end
    end

    always_comb begin
        new_ent           = '0;
        new_ent.id        = bus.enq_id;
        new_ent.fill      = bus.enq_fill && !dup_hit;
        new_ent.dup       = bus.enq_fill && dup_hit;
        new_ent.wb        = bus.enq_writeback;
        new_ent.fill_addr = bus.enq_fill_addr;
        new_ent.wb_addr   = bus.enq_wb_addr;
        new_ent.wb_data   = bus.enq_wb_data;
    end

    // Payload storage carries no reset; occupancy lives in vld_q
    always_ff @(posedge clk) begin
        if (enq_fire)
            ent_q[tail_q] <= new_ent;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            if (deq_fire) begin
                head_q        <= head_q + PW'(1);
                vld_q[head_q] <= 1'b0;
            end
            if (enq_fire) begin
                tail_q        <= tail_q + PW'(1);
                vld_q[tail_q] <= 1'b1;
            end
            case ({enq_fire, deq_fire})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d               = state_q;
        bus.mem_req_valid     = 1'b0;
        bus.mem_req_write     = 1'b0;
        bus.mem_req_addr      = '0;
        bus.mem_wvalid        = 1'b0;
        bus.mem_wdata         = '0;
        bus.mem_wlast         = 1'b0;
        bus.restart_valid     = 1'b0;
        bus.restart_id        = '0;
        bus.restart_data      = '0;
        bus.restart_duplicate = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (vld_q[head_q]) begin
                    if (head.wb)        state_d = S_WB_REQ;
                    else if (head.fill) state_d = S_FILL_REQ;
                    else                state_d = S_RESTART;
                end
            end
            S_WB_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_write = 1'b1;
                bus.mem_req_addr  = head.wb_addr;
                if (bus.mem_req_ready) state_d = S_WB_DATA;
            end
            S_WB_DATA: begin
                bus.mem_wvalid = 1'b1;
                bus.mem_wdata  = head.wb_data[beat_q*BEAT_BITS +: BEAT_BITS];
                bus.mem_wlast  = (beat_q == LAST_BEAT);
                if (bus.mem_wready && beat_q == LAST_BEAT)
                    state_d = head.fill ? S_FILL_REQ : S_RESTART;
            end
            S_FILL_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = head.fill_addr;
                if (bus.mem_req_ready) state_d = S_FILL_DATA;
            end
            S_FILL_DATA: begin
                if (bus.mem_rvalid && beat_q == LAST_BEAT) state_d = S_RESTART;
            end
            S_RESTART: begin
                bus.restart_valid     = 1'b1;
                bus.restart_id        = head.id;
                bus.restart_data      = line_q;
                bus.restart_duplicate = head.dup;
                if (bus.restart_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One beat counter serves both directions; it wraps to 0 at the end of each burst
    assign beat_adv = (state_q == S_WB_DATA && bus.mem_wready) ||
                      (state_q == S_FILL_DATA && bus.mem_rvalid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_q <= '0;
            line_q <= '0;
        end else begin
            if (beat_adv)
                beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + BCW'(1);
            if (state_q == S_FILL_DATA && bus.mem_rvalid)
                line_q[beat_q*BEAT_BITS +: BEAT_BITS] <= bus.mem_rdata;
        end
    end
endmodule
